cci_mpf_prim_rob_mc: RTL and testbench

Multi-channel reorder buffer. It holds N_CHANNELS independent in-order domains in one shared storage array, each statically given N_ENTRIES_PER_CHANNEL slots. Data for each entry arrives out of order. Each channel releases its entries strictly in allocation order, and a round-robin arbiter picks which ready channel presents on the single output port. It sits between MPF request tagging and response return, replacing several per-VC single-channel ROB instances.

---
 rtl/cci_mpf_prim_rob_mc.sv | 205 ++++++++++++++++++++
 tb/tb_cci_mpf_prim_rob_mc.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cci_mpf_prim_rob_mc.sv
// Multi-channel reorder buffer: N_CHANNELS in-order domains share one storage
// array. Payloads arrive out of order; each channel releases in allocation order
// and a round-robin arbiter picks which ready channel drives the output port.
module cci_mpf_prim_rob_mc #(
  parameter int unsigned N_CHANNELS            = 4,
  parameter int unsigned N_ENTRIES_PER_CHANNEL = 16,
  parameter int unsigned N_DATA_BITS           = 512,
  parameter int unsigned N_META_BITS           = 16,
  parameter int unsigned MAX_ALLOC_PER_CYCLE   = 4,
  parameter int unsigned MIN_FREE_SLOTS        = 4,
  localparam int unsigned CW = $clog2(N_CHANNELS),
  localparam int unsigned LW = $clog2(N_ENTRIES_PER_CHANNEL),
  localparam int unsigned AW = $clog2(MAX_ALLOC_PER_CYCLE) + 1
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic [AW-1:0]          i_alloc,
  input  logic [CW-1:0]          i_allocChan,
  input  logic [N_META_BITS-1:0] i_allocMeta,
  output logic [N_CHANNELS-1:0]  o_notFull,
  output logic [CW+LW-1:0]       o_allocIdx,
  input  logic                   i_enqData_en,
  input  logic [CW+LW-1:0]       i_enqDataIdx,
  input  logic [N_DATA_BITS-1:0] i_enqData,
  output logic                   o_notEmpty,
  output logic [CW-1:0]          o_firstChan,
  input  logic                   i_deq_en,
  output logic                   o_T1_valid,
  output logic [N_DATA_BITS-1:0] o_T1_first,
  output logic [N_META_BITS-1:0] o_T1_firstMeta,
  output logic [CW-1:0]          o_T1_firstChan,
  output logic                   o_err
);

  localparam int unsigned IW   = CW + LW;
  localparam int unsigned NE   = N_CHANNELS * N_ENTRIES_PER_CHANNEL;
  localparam int unsigned FW   = LW + 1;
  // Largest value the alloc port can carry; meta is written to every requested
  // entry even on an over-sized (erroneous) allocation.
  localparam int unsigned MAXK = (1 << AW) - 1;

  if (MIN_FREE_SLOTS < MAX_ALLOC_PER_CYCLE) begin : g_param_check
    $fatal(1, "MIN_FREE_SLOTS must be >= MAX_ALLOC_PER_CYCLE");
  end

  // Per-channel ring state
  logic [LW-1:0] r_newest [N_CHANNELS];
  logic [LW-1:0] r_oldest [N_CHANNELS];
  logic [FW-1:0] r_count  [N_CHANNELS];
  logic [NE-1:0] r_valid;

  // Arbiter state
  logic [CW-1:0] r_rr;
  logic          r_lock;
  logic [CW-1:0] r_lock_chan;
  logic          r_err;

  // Registered output stage
  logic                   r_t1_valid;
  logic [N_DATA_BITS-1:0] r_t1_first;
  logic [N_META_BITS-1:0] r_t1_meta;
  logic [CW-1:0]          r_t1_chan;

  // Shared storage, no reset
  logic [N_DATA_BITS-1:0] r_mem_data [NE];
  logic [N_META_BITS-1:0] r_mem_meta [NE];

  logic [FW-1:0]         w_free    [N_CHANNELS];
  logic [FW-1:0]         w_count_d [N_CHANNELS];
  logic [N_CHANNELS-1:0] w_not_full;
  logic [N_CHANNELS-1:0] w_cand;
  logic                  w_sel_found;
  logic [CW-1:0]         w_sel_chan;
  logic                  w_not_empty;
  logic [CW-1:0]         w_first_chan;
  logic [IW-1:0]         w_rd_idx;
  logic                  w_deq_ok;
  logic                  w_alloc_on;
  logic                  w_alloc_err;
  logic                  w_enq_err;
  logic                  w_deq_err;
  logic [NE-1:0]         w_valid_d;

  // Free-slot threshold and dequeue candidates, from registered state only
  always_comb begin
    for (int c = 0; c < N_CHANNELS; c++) begin
      w_free[c]     = FW'(N_ENTRIES_PER_CHANNEL) - r_count[c];
      w_not_full[c] = w_free[c] >= FW'(MIN_FREE_SLOTS);
      w_cand[c]     = (r_count[c] != '0) && r_valid[{CW'(c), r_oldest[c]}];
    end
  end

  // Round-robin search from r_rr; a presented channel stays locked until dequeued
  always_comb begin
    logic [CW-1:0] probe;
    probe       = r_rr;
    w_sel_found = 1'b0;
    w_sel_chan  = r_rr;
    for (int i = 0; i < N_CHANNELS; i++) begin
      probe = r_rr + CW'(i);
      if (!w_sel_found && w_cand[probe]) begin
        w_sel_found = 1'b1;
        w_sel_chan  = probe;
      end
    end
    if (r_lock) begin
      w_first_chan = r_lock_chan;
      w_not_empty  = w_cand[r_lock_chan];
    end else begin
      w_first_chan = w_sel_chan;
      w_not_empty  = w_sel_found;
    end
  end

  // Event decode, error detection and next-state counts/valid bits
  always_comb begin
    w_rd_idx    = {w_first_chan, r_oldest[w_first_chan]};
    w_deq_ok    = i_deq_en && w_not_empty;
    w_deq_err   = i_deq_en && !w_not_empty;
    w_alloc_on  = i_alloc != '0;
    w_alloc_err = w_alloc_on &&
                  (!w_not_full[i_allocChan] || (i_alloc > AW'(MAX_ALLOC_PER_CYCLE)));
    // Writing an entry that is valid covers the enq-while-dequeuing case too
    w_enq_err   = i_enqData_en && r_valid[i_enqDataIdx];

    w_valid_d = r_valid;
    if (w_deq_ok) w_valid_d[w_rd_idx] = 1'b0;
    if (i_enqData_en) w_valid_d[i_enqDataIdx] = 1'b1;

    for (int c = 0; c < N_CHANNELS; c++) begin
      w_count_d[c] = r_count[c];
      if (w_alloc_on && (i_allocChan == CW'(c))) w_count_d[c] = w_count_d[c] + FW'(i_alloc);
      if (w_deq_ok && (w_first_chan == CW'(c))) w_count_d[c] = w_count_d[c] - FW'(1);
    end
  end

  // Control state and registered output stage
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int c = 0; c < N_CHANNELS; c++) begin
        r_newest[c] <= '0;
        r_oldest[c] <= '0;
        r_count[c]  <= '0;
      end
      r_valid     <= '0;
      r_rr        <= '0;
      r_lock      <= 1'b0;
      r_lock_chan <= '0;
      r_err       <= 1'b0;
      r_t1_valid  <= 1'b0;
      r_t1_first  <= '0;
      r_t1_meta   <= '0;
      r_t1_chan   <= '0;
    end else begin
      for (int c = 0; c < N_CHANNELS; c++) begin
        r_count[c] <= w_count_d[c];
        if (w_alloc_on && (i_allocChan == CW'(c))) begin
          r_newest[c] <= r_newest[c] + LW'(i_alloc);
        end
        if (w_deq_ok && (w_first_chan == CW'(c))) begin
          r_oldest[c] <= r_oldest[c] + LW'(1);
        end
      end
      r_valid <= w_valid_d;

      if (w_deq_ok) begin
        r_rr   <= w_first_chan + CW'(1);
        r_lock <= 1'b0;
      end else if (w_not_empty) begin
        r_lock      <= 1'b1;
        r_lock_chan <= w_first_chan;
      end

      if (w_alloc_err || w_enq_err || w_deq_err) r_err <= 1'b1;

      r_t1_valid <= w_deq_ok;
      if (w_deq_ok) begin
        r_t1_first <= r_mem_data[w_rd_idx];
        r_t1_meta  <= r_mem_meta[w_rd_idx];
        r_t1_chan  <= w_first_chan;
      end
    end
  end

  // Payload and metadata storage writes
  always_ff @(posedge i_clk) begin
    if (i_enqData_en) r_mem_data[i_enqDataIdx] <= i_enqData;
    for (int k = 0; k < MAXK; k++) begin
      if (w_alloc_on && (AW'(k) < i_alloc)) begin
        r_mem_meta[{i_allocChan, r_newest[i_allocChan] + LW'(k)}] <= i_allocMeta;
      end
    end
  end

  assign o_notFull      = w_not_full;
  assign o_allocIdx     = {i_allocChan, r_newest[i_allocChan]};
  assign o_notEmpty     = w_not_empty;
  assign o_firstChan    = w_first_chan;
  assign o_T1_valid     = r_t1_valid;
  assign o_T1_first     = r_t1_first;
  assign o_T1_firstMeta = r_t1_meta;
  assign o_T1_firstChan = r_t1_chan;
  assign o_err          = r_err;

endmodule

// File: tb/tb_cci_mpf_prim_rob_mc.sv
// Bench for the multi-channel ROB: directed stimulus pushes expected dequeue
// results into a queue; an independent monitor pops and compares on T1_valid.
module tb_cci_mpf_prim_rob_mc;

  localparam int unsigned NC = 4;
  localparam int unsigned NE = 16;
  localparam int unsigned DW = 64;
  localparam int unsigned MW = 16;
  localparam int unsigned MA = 4;
  localparam int unsigned MF = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [2:0]    alloc;
  logic [1:0]    alloc_chan;
  logic [MW-1:0] alloc_meta;
  logic [3:0]    not_full;
  logic [5:0]    alloc_idx;
  logic          enq_en;
  logic [5:0]    enq_idx;
  logic [DW-1:0] enq_data;
  logic          not_empty;
  logic [1:0]    first_chan;
  logic          deq_en;
  logic          t1_valid;
  logic [DW-1:0] t1_first;
  logic [MW-1:0] t1_meta;
  logic [1:0]    t1_chan;
  logic          err;

  always #5 clk = ~clk;

  cci_mpf_prim_rob_mc #(
    .N_CHANNELS           (NC),
    .N_ENTRIES_PER_CHANNEL(NE),
    .N_DATA_BITS          (DW),
    .N_META_BITS          (MW),
    .MAX_ALLOC_PER_CYCLE  (MA),
    .MIN_FREE_SLOTS       (MF)
  ) dut (
    .i_clk          (clk),
    .i_reset_n      (reset_n),
    .i_alloc        (alloc),
    .i_allocChan    (alloc_chan),
    .i_allocMeta    (alloc_meta),
    .o_notFull      (not_full),
    .o_allocIdx     (alloc_idx),
    .i_enqData_en   (enq_en),
    .i_enqDataIdx   (enq_idx),
    .i_enqData      (enq_data),
    .o_notEmpty     (not_empty),
    .o_firstChan    (first_chan),
    .i_deq_en       (deq_en),
    .o_T1_valid     (t1_valid),
    .o_T1_first     (t1_first),
    .o_T1_firstMeta (t1_meta),
    .o_T1_firstChan (t1_chan),
    .o_err          (err)
  );

  typedef struct packed {
    logic [1:0]    chan;
    logic [DW-1:0] data;
    logic [MW-1:0] meta;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] dat(input int tag);
    return 64'(tag) * 64'h0001_0001_0001_0001 + 64'h0123_4567_89AB_0000;
  endfunction

  // Monitor: every T1 beat must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (t1_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL t1_unexpected actual=valid required=idle");
      end else begin
        mon_e = sb_q.pop_front();
        check("t1_chan", 64'(t1_chan), 64'(mon_e.chan));
        check("t1_data", t1_first, mon_e.data);
        check("t1_meta", 64'(t1_meta), 64'(mon_e.meta));
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_alloc(input int ch, input int n, input int meta, input int exp_idx);
    alloc      = 3'(n);
    alloc_chan = 2'(ch);
    alloc_meta = MW'(meta);
    #1;
    if (exp_idx >= 0) check("alloc_idx", 64'(alloc_idx), 64'(exp_idx));
    step();
    alloc = '0;
  endtask

  task automatic do_enq(input int idx, input logic [DW-1:0] d);
    enq_en   = 1'b1;
    enq_idx  = 6'(idx);
    enq_data = d;
    step();
    enq_en = 1'b0;
  endtask

  task automatic push_exp(input int ch, input logic [DW-1:0] d, input int meta);
    exp_t e;
    e.chan = 2'(ch);
    e.data = d;
    e.meta = MW'(meta);
    sb_q.push_back(e);
  endtask

  initial begin
    reset_n    = 1'b0;
    alloc      = '0;
    alloc_chan = '0;
    alloc_meta = '0;
    enq_en     = 1'b0;
    enq_idx    = '0;
    enq_data   = '0;
    deq_en     = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();

    // Reset and idle
    check("rst_not_full", 64'(not_full), 64'hF);
    check("rst_not_empty", 64'(not_empty), 64'h0);
    check("rst_t1_valid", 64'(t1_valid), 64'h0);
    check("rst_err", 64'(err), 64'h0);
    check("rst_first_chan", 64'(first_chan), 64'h0);

    // Channel 1: three entries filled in reverse order, released in order
    do_alloc(1, 3, 'hA1, 16);
    do_enq(18, dat(18));
    check("ch1_ne_after18", 64'(not_empty), 64'h0);
    do_enq(17, dat(17));
    check("ch1_ne_after17", 64'(not_empty), 64'h0);
    do_enq(16, dat(16));
    check("ch1_ne_after16", 64'(not_empty), 64'h1);
    check("ch1_first_chan", 64'(first_chan), 64'h1);
    for (int k = 0; k < 3; k++) push_exp(1, dat(16 + k), 'hA1);
    deq_en = 1'b1;
    step();
    step();
    step();
    deq_en = 1'b0;
    step();
    step();
    check("ch1_drained_ne", 64'(not_empty), 64'h0);

    // Channel 2 notFull threshold and overflow error
    for (int k = 0; k < 3; k++) do_alloc(2, 4, 'hC2, 32 + 4 * k);
    check("ch2_nf_at12", 64'(not_full), 64'hF);
    check("ch2_err_at12", 64'(err), 64'h0);
    do_alloc(2, 1, 'hC2, 44);
    check("ch2_nf_at13", 64'(not_full), 64'hB);
    check("ch2_err_at13", 64'(err), 64'h0);
    do_alloc(2, 1, 'hC2, 45);
    check("ch2_err_over", 64'(err), 64'h1);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    check("rst2_err", 64'(err), 64'h0);
    check("rst2_not_full", 64'(not_full), 64'hF);

    // Round robin between channels 0 and 3
    do_alloc(0, 2, 'hB0, 0);
    do_alloc(3, 2, 'hB3, 48);
    do_enq(0, dat(100));
    do_enq(1, dat(101));
    do_enq(48, dat(148));
    do_enq(49, dat(149));
    push_exp(0, dat(100), 'hB0);
    push_exp(3, dat(148), 'hB3);
    push_exp(0, dat(101), 'hB0);
    push_exp(3, dat(149), 'hB3);
    deq_en = 1'b1;
    for (int k = 0; k < 4; k++) step();
    deq_en = 1'b0;
    step();
    step();

    // Channel 0: 40 single-entry rounds, pointers wrap twice
    for (int r = 0; r < 40; r++) begin
      do_alloc(0, 1, 'h100 + r, (2 + r) % 16);
      do_enq((2 + r) % 16, dat('h200 + r));
      push_exp(0, dat('h200 + r), 'h100 + r);
      deq_en = 1'b1;
      step();
      deq_en = 1'b0;
    end
    step();
    step();
    check("wrap_err", 64'(err), 64'h0);
    check("wrap_not_empty", 64'(not_empty), 64'h0);
    // Count back at zero: 12 more entries keep notFull, the 13th clears it
    for (int k = 0; k < 3; k++) do_alloc(0, 4, 'hE0, (10 + 4 * k) % 16);
    check("wrap_nf_at12", 64'(not_full), 64'hF);
    do_alloc(0, 1, 'hE0, 6);
    check("wrap_nf_at13", 64'(not_full), 64'hE);
    check("wrap_err_after", 64'(err), 64'h0);

    // Dequeue with nothing ready: error, no state change
    check("bad_deq_ne", 64'(not_empty), 64'h0);
    deq_en = 1'b1;
    step();
    deq_en = 1'b0;
    check("bad_deq_err", 64'(err), 64'h1);
    alloc_chan = 2'd0;
    #1;
    check("bad_deq_newest", 64'(alloc_idx), 64'h7);
    do_enq(10, dat('h300));
    check("bad_deq_oldest_ne", 64'(not_empty), 64'h1);
    check("bad_deq_oldest_ch", 64'(first_chan), 64'h0);
    push_exp(0, dat('h300), 'hE0);
    deq_en = 1'b1;
    step();
    deq_en = 1'b0;
    step();
    step();

    // Asynchronous reset in the middle of an output beat
    do_enq(11, dat('h301));
    deq_en = 1'b1;
    @(posedge clk);
    #1;
    check("pre_reset_t1", 64'(t1_valid), 64'h1);
    deq_en  = 1'b0;
    reset_n = 1'b0;
    #1;
    check("async_t1_valid", 64'(t1_valid), 64'h0);
    check("async_not_empty", 64'(not_empty), 64'h0);
    check("async_not_full", 64'(not_full), 64'hF);
    check("async_err", 64'(err), 64'h0);
    check("async_first_chan", 64'(first_chan), 64'h0);
    step();
    step();
    check("sb_drained", 64'(sb_q.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
